// File: rtl/palindrome_stream_checker.sv
// Buffers a valid/ready symbol stream (in_last terminated) and compares pairs from both ends,
// one pair per cycle. Optional out_mis_idx port is enabled by `define PALIN_MISMATCH_IDX_EN.
module palindrome_stream_checker #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_data,
   input  logic                         in_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         out_is_pal,
   output logic                         out_overflow,
   output logic [CNT_W-1:0]             out_len
`ifdef PALIN_MISMATCH_IDX_EN
   ,output logic [$clog2(DEPTH)-1:0]    out_mis_idx
`endif
);

   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {LOAD, CHECK, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_new;
   logic [CNT_W-1:0] lo;
   logic [CNT_W-1:0] hi;
   logic             overflow;
   logic             overflow_new;
   logic             has_room;
   logic             is_pal;
   logic             in_fire;
   logic             out_fire;
   logic [WIDTH-1:0] sym_lo;
   logic [WIDTH-1:0] sym_hi;
`ifdef PALIN_MISMATCH_IDX_EN
   logic [IDX_W-1:0] mis_idx;
`endif

   assign in_ready     = (state == LOAD);
   assign out_valid    = (state == DONE);
   assign out_is_pal   = is_pal;
   assign out_overflow = overflow;
   assign out_len      = count;
`ifdef PALIN_MISMATCH_IDX_EN
   assign out_mis_idx  = mis_idx;
`endif

   assign in_fire  = in_valid & (state == LOAD);
   assign out_fire = out_ready & (state == DONE);

   // Symbols beyond DEPTH are dropped; the length saturates and overflow becomes sticky.
   assign has_room     = (count < CNT_W'(DEPTH));
   assign count_new    = has_room ? count + CNT_W'(1) : count;
   assign overflow_new = overflow | ~has_room;

   // Two combinational reads per cycle from the register array.
   assign sym_lo = mem[lo[IDX_W-1:0]];
   assign sym_hi = mem[hi[IDX_W-1:0]];

   always_ff @(posedge clk) begin
      if (in_fire && has_room) begin
         mem[count[IDX_W-1:0]] <= in_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= LOAD;
         count    <= '0;
         overflow <= 1'b0;
         is_pal   <= 1'b0;
`ifdef PALIN_MISMATCH_IDX_EN
         mis_idx  <= '0;
`endif
      end else begin
         case (state)
            LOAD: begin
               if (in_fire) begin
                  count    <= count_new;
                  overflow <= overflow_new;
                  if (in_last) begin
                     if (overflow_new) begin
                        is_pal  <= 1'b0;
`ifdef PALIN_MISMATCH_IDX_EN
                        mis_idx <= '0;
`endif
                        state   <= DONE;
                     end else begin
                        lo    <= '0;
                        hi    <= count_new - CNT_W'(1);
                        state <= CHECK;
                     end
                  end
               end
            end
            CHECK: begin
               if (lo >= hi) begin
                  is_pal  <= 1'b1;
`ifdef PALIN_MISMATCH_IDX_EN
                  mis_idx <= '0;
`endif
                  state   <= DONE;
               end else if (sym_lo != sym_hi) begin
                  is_pal  <= 1'b0;
`ifdef PALIN_MISMATCH_IDX_EN
                  mis_idx <= lo[IDX_W-1:0];
`endif
                  state   <= DONE;
               end else begin
                  lo <= lo + CNT_W'(1);
                  hi <= hi - CNT_W'(1);
               end
            end
            DONE: begin
               if (out_fire) begin
                  count    <= '0;
                  overflow <= 1'b0;
                  state    <= LOAD;
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_palindrome_stream_checker.sv
// Directed bench for palindrome_stream_checker (WIDTH=8, DEPTH=16) with immediate assertions.
module tb_palindrome_stream_checker;

   localparam int WIDTH = 8;
   localparam int DEPTH = 16;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic             out_is_pal;
   logic             out_overflow;
   logic [CNT_W-1:0] out_len;
`ifdef PALIN_MISMATCH_IDX_EN
   logic [$clog2(DEPTH)-1:0] out_mis_idx;
`endif

   int vectors = 0;
   int miscompares = 0;
   logic [WIDTH-1:0] seq [$];

   palindrome_stream_checker #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_last      (in_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_is_pal   (out_is_pal),
      .out_overflow (out_overflow),
      .out_len      (out_len)
`ifdef PALIN_MISMATCH_IDX_EN
      ,.out_mis_idx (out_mis_idx)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Sends every symbol queued in seq, in_last on the final one.
   task automatic send_seq();
      for (int i = 0; i < seq.size(); i++) begin
         in_valid = 1'b1;
         in_data  = seq[i];
         in_last  = (i == seq.size() - 1);
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   task automatic wait_result(input string tag, output int n);
      n = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) begin
         chk({tag, "_timeout"}, 32'(out_valid), 32'd1);
      end
   endtask

   task automatic run_and_check(input string tag, input int exp_n, input bit chk_n,
                                input bit exp_pal, input int exp_len, input bit exp_ovf,
                                input int exp_mis);
      int n;
      send_seq();
      wait_result(tag, n);
      if (chk_n) chk({tag, "_latency"}, 32'(n), 32'(exp_n));
      chk({tag, "_is_pal"}, 32'(out_is_pal), 32'(exp_pal));
      chk({tag, "_len"}, 32'(out_len), 32'(exp_len));
      chk({tag, "_overflow"}, 32'(out_overflow), 32'(exp_ovf));
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
`ifdef PALIN_MISMATCH_IDX_EN
      chk({tag, "_mis_idx"}, 32'(out_mis_idx), 32'(exp_mis));
`else
      if (exp_mis < 0) $display("unexpected negative index for %s", tag);
`endif
   endtask

   task automatic consume(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_post_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_post_len"}, 32'(out_len), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_is_pal", 32'(out_is_pal), 32'd0);
      chk("reset_overflow", 32'(out_overflow), 32'd0);
      chk("reset_len", 32'(out_len), 32'd0);
`ifdef PALIN_MISMATCH_IDX_EN
      chk("reset_mis_idx", 32'(out_mis_idx), 32'd0);
`endif

      seq = '{8'h61, 8'h62, 8'h62, 8'h61};
      run_and_check("abba", 3, 1'b1, 1'b1, 4, 1'b0, 0);
      consume("abba");

      seq = '{8'h05, 8'h03, 8'h09};
      run_and_check("539", 1, 1'b1, 1'b0, 3, 1'b0, 0);
      consume("539");

      seq = '{8'h08};
      run_and_check("single", 1, 1'b1, 1'b1, 1, 1'b0, 0);
      consume("single");

      seq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd1};
      run_and_check("mis_pair1", 2, 1'b1, 1'b0, 10, 1'b0, 1);
      consume("mis_pair1");

      seq = {};
      for (int i = 0; i < 17; i++) seq.push_back(8'(i + 1));
      run_and_check("ovf17", 0, 1'b0, 1'b0, 16, 1'b1, 0);
      consume("ovf17");

      seq = '{8'd7, 8'd7};
      run_and_check("after_ovf", 2, 1'b1, 1'b1, 2, 1'b0, 0);
      consume("after_ovf");

      seq = '{8'd0, 8'd1, 8'd0};
      run_and_check("zero_pal", 2, 1'b1, 1'b1, 3, 1'b0, 0);
      consume("zero_pal");

      seq = '{8'd0, 8'd1};
      run_and_check("zero_nopal", 1, 1'b1, 1'b0, 2, 1'b0, 0);
      consume("zero_nopal");

      // Full-depth palindrome, then hold the result with out_ready low.
      seq = {};
      for (int i = 0; i < DEPTH; i++) seq.push_back(8'(i < 8 ? 8'h30 + i : 8'h30 + 15 - i));
      run_and_check("full16", 9, 1'b1, 1'b1, 16, 1'b0, 0);
      in_valid = 1'b1;
      in_data  = 8'hAA;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_is_pal", 32'(out_is_pal), 32'd1);
         chk("stall_len", 32'(out_len), 32'd16);
      end
      in_valid = 1'b0;
      consume("full16");

      // Reset two cycles into CHECK aborts the sequence.
      send_seq();
      tick();
      chk("midcheck_valid", 32'(out_valid), 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_valid", 32'(out_valid), 32'd0);
      chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
      chk("rst_mid_len", 32'(out_len), 32'd0);
      for (int c = 0; c < 12; c++) tick();
      chk("rst_mid_no_result", 32'(out_valid), 32'd0);

      seq = '{8'h08};
      run_and_check("post_rst", 1, 1'b1, 1'b1, 1, 1'b0, 0);
      consume("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
